dwpe_feeder: RTL and testbench

Operand sequencer that drives the depthwise PE (dwpe) operand interface.
- Collects NMAX tap weights and one pixel row segment of POX+NMAX-1 pixels from an upstream stream.
- Replays them into dwpe as a sliding window: one tap per cycle, pixel window shifted by one per tap.
- Holds dwpe_ena until dwpe reports result_valid, then signals done.
- Sits between the on-chip buffer read path and dwpe.

---
 rtl/dwpe_pkg.sv | 25 ++
 rtl/dwpe_window_buf.sv | 70 +++++++
 rtl/dwpe_feeder.sv | 159 +++++++++++++++
 tb/tb_dwpe_feeder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwpe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dwpe_pkg
// Description : Shared types, default geometry and helpers for dwpe blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package dwpe_pkg;

    localparam int c_DW    = 32;
    localparam int c_POX   = 6;
    localparam int c_KSIZE = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        RUN      = 2'd2,
        WAIT_RES = 2'd3
    } feeder_state_t;

    function automatic int nmax(input int ksize);
        return ksize * ksize;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwpe_window_buf.sv
`default_nettype none
// ============================================================================
// Module      : dwpe_window_buf
// Description : Weight/pixel storage with write pointer and tap-indexed
//               sliding-window read mux for the dwpe feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module dwpe_window_buf
    import dwpe_pkg::*;
#(
    parameter int DW   = c_DW,
    parameter int POX  = c_POX,
    parameter int NMAX = nmax(c_KSIZE),
    parameter int KW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic [KW-1:0] rd_tap,
    output logic          wr_last,
    output logic [DW-1:0] rd_pix [POX],
    output logic [DW-1:0] rd_wt
);

    localparam int NPIX   = POX + NMAX - 1;
    localparam int NWORDS = NMAX + NPIX;
    localparam int PW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PIW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [PW-1:0] c_LAST   = PW'(NWORDS - 1);
    localparam logic [PW-1:0] c_NMAX_P = PW'(NMAX);

    logic [PW-1:0] r_wptr;
    logic [DW-1:0] r_wbuf [NMAX];
    logic [DW-1:0] r_pbuf [NPIX];

    assign wr_last = wr_en && (r_wptr == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (wr_en) begin
            r_wptr <= wr_last ? '0 : r_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NMAX; j++) r_wbuf[j] <= '0;
            for (int j = 0; j < NPIX; j++) r_pbuf[j] <= '0;
        end else if (wr_en) begin
            if (r_wptr < c_NMAX_P) r_wbuf[KW'(r_wptr)] <= wr_data;
            else                   r_pbuf[PIW'(r_wptr - c_NMAX_P)] <= wr_data;
        end
    end

    // The word being written this cycle is forwarded so the first window can
    // be registered on the same edge that stores the final stream word.
    for (genvar i = 0; i < POX; i++) begin : g_rd_pix
        logic [PIW-1:0] w_idx;
        logic           w_fwd;
        assign w_idx     = PIW'(i) + PIW'(rd_tap);
        assign w_fwd     = wr_en && (r_wptr == c_NMAX_P + PW'(w_idx));
        assign rd_pix[i] = w_fwd ? wr_data : r_pbuf[w_idx];
    end

    assign rd_wt = (wr_en && (r_wptr == PW'(rd_tap))) ? wr_data : r_wbuf[rd_tap];

endmodule
`default_nettype wire

// File: rtl/dwpe_feeder.sv
`default_nettype none
// ============================================================================
// Module      : dwpe_feeder
// Description : Loads NMAX weights plus a POX+NMAX-1 pixel segment, then
//               replays them into dwpe as a sliding window, one tap per cycle.
//               Optional WAIT_RES timeout: define DWPE_FEEDER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dwpe_feeder
    import dwpe_pkg::*;
#(
    parameter int DW      = c_DW,
    parameter int POX     = c_POX,
    parameter int KSIZE   = c_KSIZE,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] pixel_array [POX],
    output logic [DW-1:0] weight,
    output logic          dwpe_ena,
    input  logic          result_valid,
    output logic          busy,
    output logic          done
`ifdef DWPE_FEEDER_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    localparam int NMAX = nmax(KSIZE);
    localparam int KW   = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam logic [KW-1:0] c_LAST_TAP = KW'(NMAX - 1);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dwpe_feeder: TIMEOUT must be at least 1");
    end

    feeder_state_t r_state;
    logic [KW-1:0] r_k;
    logic          r_in_ready;
    logic          r_ena;
    logic          r_done;
    logic [DW-1:0] r_wt;
    logic [DW-1:0] r_pix [POX];

    logic          w_wr_en;
    logic          w_last;
    logic [KW-1:0] w_rd_tap;
    logic [DW-1:0] w_rd_wt;
    logic [DW-1:0] w_rd_pix [POX];

    assign w_wr_en  = (r_state == LOAD) && in_valid;
    // Read the tap that the output registers will present next cycle.
    assign w_rd_tap = ((r_state == RUN) && (r_k != c_LAST_TAP)) ? r_k + 1'b1 : '0;

    dwpe_window_buf #(
        .DW   (DW),
        .POX  (POX),
        .NMAX (NMAX),
        .KW   (KW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_data (in_data),
        .rd_tap  (w_rd_tap),
        .wr_last (w_last),
        .rd_pix  (w_rd_pix),
        .rd_wt   (w_rd_wt)
    );

`ifdef DWPE_FEEDER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] c_TLAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_tcnt;
    logic          r_err;
    assign timeout_err = r_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_ena      <= 1'b0;
            r_done     <= 1'b0;
            r_wt       <= '0;
            for (int i = 0; i < POX; i++) r_pix[i] <= '0;
`ifdef DWPE_FEEDER_TIMEOUT_EN
            r_tcnt     <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= LOAD;
                        r_in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_last) begin
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_ena      <= 1'b1;
                        r_k        <= '0;
                        r_pix      <= w_rd_pix;
                        r_wt       <= w_rd_wt;
                    end
                end
                RUN: begin
                    if (r_k == c_LAST_TAP) begin
                        r_state <= WAIT_RES;
`ifdef DWPE_FEEDER_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end else begin
                        r_k   <= r_k + 1'b1;
                        r_pix <= w_rd_pix;
                        r_wt  <= w_rd_wt;
                    end
                end
                WAIT_RES: begin
                    if (result_valid) begin
                        r_state <= IDLE;
                        r_ena   <= 1'b0;
                        r_done  <= 1'b1;
                    end
`ifdef DWPE_FEEDER_TIMEOUT_EN
                    else if (r_tcnt == c_TLAST) begin
                        r_state <= IDLE;
                        r_ena   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign dwpe_ena    = r_ena;
    assign done        = r_done;
    assign weight      = r_wt;
    assign pixel_array = r_pix;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dwpe_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dwpe_feeder
// Description : Self-checking bench for dwpe_feeder against a sequence-level
//               reference model (word list + tap index), random and directed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dwpe_feeder;
    import dwpe_pkg::*;

    localparam int DW   = 32;
    localparam int POX  = 6;
    localparam int NMAX = 4;
    localparam int NPIX = POX + NMAX - 1;
    localparam int NW   = NMAX + NPIX;
    localparam int TOUT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          result_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, dwpe_ena, busy, done;
    logic [DW-1:0] weight;
    logic [DW-1:0] pixel_array [POX];
`ifdef DWPE_FEEDER_TIMEOUT_EN
    logic          timeout_err;
`endif

    always #5 clk = ~clk;

    dwpe_feeder #(.DW(DW), .POX(POX), .KSIZE(2), .TIMEOUT(TOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .pixel_array  (pixel_array),
        .weight       (weight),
        .dwpe_ena     (dwpe_ena),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done)
`ifdef DWPE_FEEDER_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: phase 0 idle, 1 loading, 2 replaying taps, 3 waiting.
    int          m_phase = 0;
    int          m_cnt   = 0;
    int          m_k     = 0;
    int          m_wcnt  = 0;
    logic        m_done  = 1'b0;
    logic        m_err   = 1'b0;
    logic [31:0] m_words [NW];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_k = 0; m_wcnt = 0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_phase)
                0: if (start) begin m_phase = 1; m_cnt = 0; end
                1: if (in_valid) begin
                       m_words[m_cnt] = in_data;
                       m_cnt++;
                       if (m_cnt == NW) begin m_phase = 2; m_k = 0; end
                   end
                2: if (m_k == NMAX - 1) begin m_phase = 3; m_wcnt = 0; end
                   else m_k++;
                default: begin
                    m_wcnt++;
                    if (result_valid) begin m_phase = 0; m_done = 1'b1; end
`ifdef DWPE_FEEDER_TIMEOUT_EN
                    else if (m_wcnt == TOUT) begin m_phase = 0; m_done = 1'b1; m_err = 1'b1; end
`endif
                end
            endcase
        end
    end

    logic [31:0]         cap_w [$];
    logic [POX*DW-1:0]   cap_p [$];
    int                  cap_rdy = 0;
    int                  cap_acc = 0;
    int                  done_cnt = 0;
    logic [POX*DW-1:0]   ap, ep;

    always @(negedge clk) begin
        for (int i = 0; i < POX; i++) begin
            ap[i*DW +: DW] = pixel_array[i];
            ep[i*DW +: DW] = m_words[NMAX + i + m_k];
        end
        chk("in_ready", in_ready, m_phase == 1);
        chk("dwpe_ena", dwpe_ena, m_phase >= 2);
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_done);
`ifdef DWPE_FEEDER_TIMEOUT_EN
        chk("timeout_err", timeout_err, m_err);
`endif
        if (m_phase >= 2) begin
            chk("weight", weight, m_words[m_k]);
            chk("window", ap, ep);
        end
        if (dwpe_ena) begin cap_w.push_back(weight); cap_p.push_back(ap); end
        if (in_ready) cap_rdy++;
        if (in_ready && in_valid) cap_acc++;
        if (done) done_cnt++;
    end

    task automatic clear_cap();
        cap_w.delete(); cap_p.delete(); cap_rdy = 0; cap_acc = 0;
    endtask

    // gap: 0 continuous, 1 toggle, 2 random; rvd<0 never asserts result_valid
    task automatic run_seq(input logic [31:0] w [NMAX], input logic [31:0] p [NPIX],
                           input int gap, input int rvd, input bit idle_valid,
                           input bit run_start, input int abort_k);
        logic [31:0]       words [NW];
        logic [POX*DW-1:0] pk;
        int idx, g;
        for (int j = 0; j < NMAX; j++) words[j] = w[j];
        for (int j = 0; j < NPIX; j++) words[NMAX + j] = p[j];
        start = 1'b1; in_valid = idle_valid; in_data = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        idx = 0; g = 0;
        while (idx < NW && g < 400) begin
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = (g % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = words[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            tick();
            g++;
        end
        in_valid = 1'b0;
        if (idx != NW) begin chk("load_bound", idx, NW); return; end
        for (int c = 0; c < NMAX; c++) begin
            if (c == abort_k) begin
                rst = 1'b1;
                #1;
                for (int i = 0; i < POX; i++) pk[i*DW +: DW] = pixel_array[i];
                chk("abort_pix", pk, 0);
                chk("abort_wt", weight, 0);
                chk("abort_ena", dwpe_ena, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                tick();
                rst = 1'b0;
                tick();
                return;
            end
            start = run_start && (c == 1);
            tick();
        end
        start = 1'b0;
        if (rvd >= 0) begin
            repeat (rvd) tick();
            result_valid = 1'b1;
            tick();
            result_valid = 1'b0;
        end
        g = 0;
        while (busy && g < 100) begin tick(); g++; end
        chk("seq_idle", busy, 0);
        tick();
    endtask

    logic [31:0] w [NMAX];
    logic [31:0] p [NPIX];
    logic [31:0] wseq [7];
    int d0;

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ena", dwpe_ena, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wt", weight, 0);
        rst = 1'b0;
        tick();

        // continuous load, uniform weights
        w = '{3, 3, 3, 3};
        p = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        clear_cap(); d0 = done_cnt;
        run_seq(w, p, 0, 2, 1'b0, 1'b0, -1);
        chk("t1_ready_cycles", cap_rdy, 13);
        chk("t1_k0_win", cap_p[0], {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        chk("t1_k3_win", cap_p[3], {32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4});
        chk("t1_k0_wt", cap_w[0], 3);
        chk("t1_done", done_cnt, d0 + 1);

        // distinct weights, result two cycles into WAIT_RES
        w = '{1, 2, 3, 4};
        wseq = '{1, 2, 3, 4, 4, 4, 4};
        clear_cap(); d0 = done_cnt;
        run_seq(w, p, 0, 2, 1'b0, 1'b0, -1);
        chk("t2_ena_cycles", cap_w.size(), 7);
        for (int j = 0; j < 7; j++) chk("t2_wt_seq", cap_w[j], wseq[j]);
        chk("t2_done", done_cnt, d0 + 1);

        // toggled in_valid
        w = '{3, 3, 3, 3};
        clear_cap(); d0 = done_cnt;
        run_seq(w, p, 1, 0, 1'b0, 1'b0, -1);
        chk("t3_accepted", cap_acc, 13);
        chk("t3_k0_win", cap_p[0], {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        chk("t3_k3_win", cap_p[3], {32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4});

        // start with in_valid in IDLE, start pulse during RUN
        clear_cap(); d0 = done_cnt;
        run_seq(w, p, 0, 1, 1'b1, 1'b1, -1);
        chk("t4_accepted", cap_acc, 13);
        chk("t4_k0_win", cap_p[0], {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        chk("t4_done", done_cnt, d0 + 1);
        repeat (3) tick();
        chk("t4_no_restart", busy, 0);

        // reset during RUN k=2, then a fresh sequence
        d0 = done_cnt;
        run_seq(w, p, 0, 0, 1'b0, 1'b0, 2);
        chk("t5_no_done", done_cnt, d0);
        w = '{1, 2, 3, 4};
        clear_cap();
        run_seq(w, p, 0, 0, 1'b0, 1'b0, -1);
        chk("t5_after_done", done_cnt, d0 + 1);
        chk("t5_k0_wt", cap_w[0], 1);

        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < NMAX; j++) w[j] = $urandom;
            for (int j = 0; j < NPIX; j++) p[j] = $urandom;
            d0 = done_cnt;
            run_seq(w, p, 2, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
            chk("rand_done", done_cnt, d0 + 1);
        end

`ifdef DWPE_FEEDER_TIMEOUT_EN
        d0 = done_cnt;
        run_seq(w, p, 0, -1, 1'b0, 1'b0, -1);
        chk("to_err", timeout_err, 1);
        chk("to_done", done_cnt, d0 + 1);
        chk("to_ena", dwpe_ena, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
